// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package sram_arb_pkg;

    // Arbitration priority state, kept as plain constants for legacy tools.
    typedef logic [0:0] arb_state_e;
    localparam arb_state_e DM_PRI = 1'b0;
    localparam arb_state_e IM_PRI = 1'b1;

    // Tag travelling alongside each SRAM command until its read data returns.
    typedef struct packed {
        logic valid_read;
        logic is_dm;
    } rsp_tag_t;

    // Byte write enables are active-low: all lanes high means a read.
    localparam logic [3:0] WEB_READ = 4'hF;

endpackage

// File: rtl/sram_rsp_pipe.sv
// Two-deep response tag pipeline that steers returning SRAM read data to the
// requester that issued the read.
module sram_rsp_pipe
    import sram_arb_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_issued,
    input  logic                 issued_dm,
    input  logic [WORD_SIZE-1:0] sram_DI,
    output logic                 im_rvalid,
    output logic [WORD_SIZE-1:0] im_rdata,
    output logic                 dm_rvalid,
    output logic [WORD_SIZE-1:0] dm_rdata
);

    rsp_tag_t             tag_q [2];
    logic [WORD_SIZE-1:0] im_hold;
    logic [WORD_SIZE-1:0] dm_hold;

    // Stage 0 aligns with the command on the SRAM pins, stage 1 with its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q[0] <= '0;
            tag_q[1] <= '0;
        end else begin
            tag_q[0] <= '{valid_read: read_issued, is_dm: issued_dm};
            tag_q[1] <= tag_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_hold <= '0;
            dm_hold <= '0;
        end else begin
            if (im_rvalid) im_hold <= sram_DI;
            if (dm_rvalid) dm_hold <= sram_DI;
        end
    end

    // Read data passes straight through in its valid cycle, then holds.
    always_comb begin
        im_rvalid = tag_q[1].valid_read && !tag_q[1].is_dm;
        dm_rvalid = tag_q[1].valid_read &&  tag_q[1].is_dm;
        im_rdata  = im_rvalid ? sram_DI : im_hold;
        dm_rdata  = dm_rvalid ? sram_DI : dm_hold;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between instruction-fetch and data ports with
// data priority, an instruction starvation guard and tagged read responses.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int BYTES     = 4,
    parameter int MAX_WAIT  = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 im_req,
    input  logic [BYTES-1:0]     im_web,
    input  logic [ADDR_SIZE-1:0] im_addr,
    input  logic [WORD_SIZE-1:0] im_wdata,
    output logic                 im_gnt,
    output logic                 im_rvalid,
    output logic [WORD_SIZE-1:0] im_rdata,
    input  logic                 dm_req,
    input  logic [BYTES-1:0]     dm_web,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic                 dm_gnt,
    output logic                 dm_rvalid,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 sram_oe,
    output logic [BYTES-1:0]     sram_web,
    output logic [ADDR_SIZE-1:0] sram_addr,
    input  logic [WORD_SIZE-1:0] sram_DI,
    output logic [WORD_SIZE-1:0] sram_DO
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C     = CNT_W'(MAX_WAIT);
    localparam bit               MAX_WAIT_LEGAL = (MAX_WAIT >= 1) && (MAX_WAIT < (1 << CNT_W));

    arb_state_e           state;
    arb_state_e           state_next;
    logic [CNT_W-1:0]     starv_cnt;
    logic [CNT_W-1:0]     starv_next;
    logic                 im_win;
    logic                 dm_win;
    logic                 any_win;
    logic                 win_is_read;
    logic [BYTES-1:0]     win_web;
    logic [ADDR_SIZE-1:0] win_addr;
    logic [WORD_SIZE-1:0] win_wdata;

    // NOTE: every output of this block is assigned on every path, so no latches.
    always_comb begin
        im_win      = im_req && ((state == IM_PRI) || !dm_req);
        dm_win      = dm_req && !im_win;
        any_win     = im_win || dm_win;
        win_web     = dm_win ? dm_web   : im_web;
        win_addr    = dm_win ? dm_addr  : im_addr;
        win_wdata   = dm_win ? dm_wdata : im_wdata;
        win_is_read = any_win && (&win_web);

        if (im_req && !im_win) begin
            starv_next = (starv_cnt == MAX_WAIT_C) ? MAX_WAIT_C : starv_cnt + CNT_W'(1);
        end else begin
            starv_next = '0;
        end

        state_next = state;
        case (state)
            DM_PRI:  if (starv_next == MAX_WAIT_C) state_next = IM_PRI;
            IM_PRI:  if (im_win) state_next = DM_PRI;
            default: state_next = DM_PRI;
        endcase
    end

    assign im_gnt = im_win;
    assign dm_gnt = dm_win;

    // NOTE: registered state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DM_PRI;
            starv_cnt <= '0;
        end else begin
            state     <= state_next;
            starv_cnt <= starv_next;
        end
    end

    // Address and write data only move on a grant; idle cycles leave them parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_oe   <= 1'b0;
            sram_web  <= '1;
            sram_addr <= '0;
            sram_DO   <= '0;
        end else if (any_win) begin
            sram_addr <= win_addr;
            if (&win_web) begin
                sram_oe  <= 1'b1;
                sram_web <= '1;
            end else begin
                sram_oe  <= 1'b0;
                sram_web <= win_web;
                sram_DO  <= win_wdata;
            end
        end else begin
            sram_oe  <= 1'b0;
            sram_web <= '1;
        end
    end

    sram_rsp_pipe #(
        .WORD_SIZE (WORD_SIZE)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst         (rst),
        .read_issued (win_is_read),
        .issued_dm   (dm_win),
        .sram_DI     (sram_DI),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .dm_rvalid   (dm_rvalid),
        .dm_rdata    (dm_rdata)
    );

    always_ff @(posedge clk) begin
        assert (MAX_WAIT_LEGAL)
            else $error("sram_port_arbiter: MAX_WAIT=%0d does not fit CNT_W=%0d", MAX_WAIT, CNT_W);
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scoreboard bench for sram_port_arbiter: stimulus queues expected
// SRAM commands and read responses, a negedge monitor pops and compares them.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req, dm_req;
    logic [3:0]  im_web, dm_web;
    logic [31:0] im_addr, dm_addr, im_wdata, dm_wdata;
    logic        im_gnt, dm_gnt, im_rvalid, dm_rvalid;
    logic [31:0] im_rdata, dm_rdata;
    logic        sram_oe;
    logic [3:0]  sram_web;
    logic [31:0] sram_addr, sram_DI, sram_DO;

    typedef struct { logic [3:0] web; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct { bit is_dm; logic [31:0] data; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    sram_port_arbiter #(
        .ADDR_SIZE (32), .WORD_SIZE (32), .BYTES (4), .MAX_WAIT (4), .CNT_W (3)
    ) dut (
        .clk       (clk),       .rst       (rst),
        .im_req    (im_req),    .im_web    (im_web),    .im_addr  (im_addr),
        .im_wdata  (im_wdata),  .im_gnt    (im_gnt),    .im_rvalid(im_rvalid),
        .im_rdata  (im_rdata),
        .dm_req    (dm_req),    .dm_web    (dm_web),    .dm_addr  (dm_addr),
        .dm_wdata  (dm_wdata),  .dm_gnt    (dm_gnt),    .dm_rvalid(dm_rvalid),
        .dm_rdata  (dm_rdata),
        .sram_oe   (sram_oe),   .sram_web  (sram_web),  .sram_addr(sram_addr),
        .sram_DI   (sram_DI),   .sram_DO   (sram_DO)
    );

    always #5 clk = ~clk;

    // Hand-picked SRAM contents for the addresses the bench reads.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'h1111_1111;
            32'h0000_0004: return 32'h2222_2222;
            32'h0000_0008: return 32'h3333_3333;
            default:       return 32'hBAD0_0000 ^ a;
        endcase
    endfunction

    // SRAM stand-in: data appears the cycle after a read command, noise otherwise.
    always @(posedge clk) sram_DI <= sram_oe ? mem_word(sram_addr) : $urandom();

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic push(input bit is_dm, input logic [3:0] web, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit drop_rsp);
        cmd_q.push_back('{web: web, addr: addr, wdata: wdata});
        if (web == WEB_READ && !drop_rsp) rsp_q.push_back('{is_dm: is_dm, data: mem_word(addr)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the grants of the current cycle and queues what the winner should cause.
    task automatic expect_cycle(input bit exp_im, input bit exp_dm, input string tag, input bit drop_rsp);
        @(negedge clk);
        check({tag, "_im_gnt"}, im_gnt, exp_im);
        check({tag, "_dm_gnt"}, dm_gnt, exp_dm);
        if (exp_im) push(1'b0, im_web, im_addr, im_wdata, drop_rsp);
        if (exp_dm) push(1'b1, dm_web, dm_addr, dm_wdata, drop_rsp);
    endtask

    always @(negedge clk) begin
        check("single_gnt", im_gnt & dm_gnt, 1'b0);
        check("gnt_without_req", (im_gnt & ~im_req) | (dm_gnt & ~dm_req), 1'b0);
        if (im_rvalid === 1'b1 || dm_rvalid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rvalid", {im_rvalid, dm_rvalid}, 2'b00);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                check("rvalid_port", {im_rvalid, dm_rvalid}, r.is_dm ? 2'b01 : 2'b10);
                check("rdata", r.is_dm ? dm_rdata : im_rdata, r.data);
            end
        end
        if (sram_oe === 1'b1 || sram_web !== 4'hF) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_cmd", {sram_oe, sram_web}, 5'b0_1111);
            end else begin
                cmd_t c;
                c = cmd_q.pop_front();
                check("cmd_oe", sram_oe, c.web == WEB_READ);
                check("cmd_web", sram_web, c.web);
                check("cmd_addr", sram_addr, c.addr);
                if (c.web != WEB_READ) check("cmd_do", sram_DO, c.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] im_pattern;
        rst = 1'b1;
        im_req = 1'b0; im_web = 4'hF; im_addr = '0; im_wdata = '0;
        dm_req = 1'b0; dm_web = 4'hF; dm_addr = '0; dm_wdata = '0;
        repeat (3) tick();

        @(negedge clk);
        check("rst_oe", sram_oe, 1'b0);
        check("rst_web", sram_web, 4'hF);
        check("rst_addr", sram_addr, 32'h0);
        check("rst_do", sram_DO, 32'h0);
        check("rst_rvalid", {im_rvalid, dm_rvalid}, 2'b00);
        check("rst_rdata", {im_rdata, dm_rdata}, 64'h0);
        tick();
        rst = 1'b0;

        // Single instruction read.
        im_req = 1'b1; im_web = 4'hF; im_addr = 32'h10;
        expect_cycle(1'b1, 1'b0, "im_read", 1'b0);
        tick();
        im_req = 1'b0;
        @(negedge clk);
        check("im_read_n1_oe", sram_oe, 1'b1);
        check("im_read_n1_addr", sram_addr, 32'h10);
        check("im_read_n1_rvalid", im_rvalid, 1'b0);
        tick();
        @(negedge clk);
        check("im_read_n2_rvalid", im_rvalid, 1'b1);
        check("im_read_n2_rdata", im_rdata, 32'hDEAD_BEEF);
        check("im_read_n2_dm_rvalid", dm_rvalid, 1'b0);
        tick();

        // Partial data write.
        dm_req = 1'b1; dm_web = 4'b1100; dm_addr = 32'h20; dm_wdata = 32'hA5A5_1234;
        expect_cycle(1'b0, 1'b1, "dm_write", 1'b0);
        tick();
        dm_req = 1'b0; dm_web = 4'hF;
        @(negedge clk);
        check("dm_write_web", sram_web, 4'b1100);
        check("dm_write_do", sram_DO, 32'hA5A5_1234);
        check("dm_write_oe", sram_oe, 1'b0);
        tick();
        @(negedge clk);
        check("dm_write_no_rvalid", dm_rvalid, 1'b0);
        tick();

        // Back-to-back data reads give consecutive rvalids in order.
        for (int i = 0; i < 6; i++) begin
            dm_req = (i < 3);
            dm_addr = 32'(i * 4);
            expect_cycle(1'b0, i < 3, "dm_b2b", 1'b0);
            check("dm_b2b_rvalid", dm_rvalid, (i >= 2) && (i <= 4));
            tick();
        end

        // Continuous contention: instruction port wins every fifth cycle.
        im_pattern = 15'h4210;
        im_req = 1'b1; im_web = 4'h0; im_addr = 32'h100; im_wdata = 32'h1;
        dm_req = 1'b1; dm_web = 4'h0; dm_addr = 32'h200; dm_wdata = 32'h2;
        for (int i = 0; i < 15; i++) begin
            expect_cycle(im_pattern[i], !im_pattern[i], "starve", 1'b0);
            tick();
        end

        // Reset the cycle after a read grant, with the FSM about to flip priority.
        for (int i = 0; i < 3; i++) begin
            expect_cycle(1'b0, 1'b1, "pre_rst", 1'b0);
            tick();
        end
        dm_web = 4'hF; dm_addr = 32'h10;
        expect_cycle(1'b0, 1'b1, "rst_read", 1'b1);
        tick();
        rst = 1'b1; im_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_oe", sram_oe, 1'b1);
        tick();
        @(negedge clk);
        check("rst_mid_oe", sram_oe, 1'b0);
        check("rst_mid_web", sram_web, 4'hF);
        check("rst_mid_rvalid", {im_rvalid, dm_rvalid}, 2'b00);
        tick();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rvalid", {im_rvalid, dm_rvalid}, 2'b00);
            tick();
        end
        im_req = 1'b1; dm_req = 1'b1; dm_web = 4'h0; dm_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            expect_cycle(i == 4, i != 4, "post_rst_arb", 1'b0);
            tick();
        end
        im_req = 1'b0; dm_req = 1'b0;

        // Idle: nothing granted, SRAM quiet, address parked on the last write.
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt", {im_gnt, dm_gnt}, 2'b00);
            check("idle_oe", sram_oe, 1'b0);
            check("idle_web", sram_web, 4'hF);
            check("idle_addr", sram_addr, 32'h100);
            tick();
        end

        repeat (3) tick();
        check("cmd_queue_drained", cmd_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
